// File: rtl/fbcpu_pkg.sv
// Shared sizing and state encoding for the FBCPU program loader and its RAM.
package fbcpu_pkg;

   localparam int unsigned AddrWidth = 6;
   localparam int unsigned DataWidth = 10;
   localparam int unsigned Depth     = 2 ** AddrWidth;

   typedef enum logic [1:0] {
      StClear = 2'd0,
      StLoad  = 2'd1,
      StRun   = 2'd2
   } state_e;

endpackage

// File: rtl/fbcpu_ram.sv
// Single-port synchronous read-first program RAM; the write source (clear, host load or CPU)
// is picked by the loader state.
module fbcpu_ram
   import fbcpu_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = AddrWidth,
   parameter int unsigned DATA_WIDTH    = DataWidth
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  state_e                   state_i,
   input  logic [ADDRESS_WIDTH-1:0] clr_addr_i,
   input  logic [ADDRESS_WIDTH-1:0] ld_addr_i,
   input  logic [DATA_WIDTH-1:0]    ld_data_i,
   input  logic                     ld_we_i,
   input  logic [ADDRESS_WIDTH-1:0] mar_i,
   input  logic [DATA_WIDTH-1:0]    mdr_in_i,
   input  logic                     ram_wr_i,
   output logic [DATA_WIDTH-1:0]    rd_data_o
);

   localparam int unsigned Words = 2 ** ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0]    mem [Words];
   logic                     we;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0]    wdata;
   logic [DATA_WIDTH-1:0]    rd_data_q;

   always_comb begin
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      unique case (state_i)
         StClear: begin
            we    = 1'b1;
            addr  = clr_addr_i;
         end
         StLoad: begin
            we    = ld_we_i;
            addr  = ld_addr_i;
            wdata = ld_data_i;
         end
         StRun: begin
            we    = ram_wr_i;
            addr  = mar_i;
            wdata = mdr_in_i;
         end
         default: ;
      endcase
   end

   // Contents survive rst on purpose; the CLEAR pass is what zeroes them.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (state_i == StRun) begin
         rd_data_q <= mem[addr];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fbcpu_mem_loader.sv
// Program loader for FBCPU: clears the RAM, accepts a host load session, then hands the RAM
// to the CPU and releases its reset.
module fbcpu_mem_loader
   import fbcpu_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = AddrWidth,
   parameter int unsigned DATA_WIDTH    = DataWidth
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [DATA_WIDTH-1:0]    ld_data,
   input  logic                     ld_last,
   input  logic                     ld_start,
   input  logic [ADDRESS_WIDTH-1:0] MAR,
   input  logic [DATA_WIDTH-1:0]    MDRIn,
   input  logic                     RAMWr,
   output logic [DATA_WIDTH-1:0]    MDROut,
   output logic                     cpu_rst,
   output logic [ADDRESS_WIDTH:0]   load_count,
   output logic                     load_err
);

   state_e                   state_q;
   logic [ADDRESS_WIDTH-1:0] clr_addr_q;
   logic [ADDRESS_WIDTH:0]   load_count_q;
   logic                     load_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StClear;
         clr_addr_q   <= '0;
         load_count_q <= '0;
         load_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StClear: begin
               clr_addr_q <= clr_addr_q + ADDRESS_WIDTH'(1);
               if (&clr_addr_q) begin
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               if (ld_valid) begin
                  load_count_q <= load_count_q + (ADDRESS_WIDTH + 1)'(1);
                  if (ld_last) begin
                     state_q <= StRun;
                  end else if (&load_count_q[ADDRESS_WIDTH-1:0]) begin
                     // RAM is full and the host never flagged the end of the program.
                     load_err_q <= 1'b1;
                     state_q    <= StRun;
                  end
               end
            end
            StRun: begin
               if (ld_start) begin
                  state_q      <= StClear;
                  clr_addr_q   <= '0;
                  load_count_q <= '0;
                  load_err_q   <= 1'b0;
               end
            end
            default: state_q <= StClear;
         endcase
      end
   end

   fbcpu_ram #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_ram (
      .clk_i      (clk),
      .rst_i      (rst),
      .state_i    (state_q),
      .clr_addr_i (clr_addr_q),
      .ld_addr_i  (load_count_q[ADDRESS_WIDTH-1:0]),
      .ld_data_i  (ld_data),
      .ld_we_i    (ld_valid),
      .mar_i      (MAR),
      .mdr_in_i   (MDRIn),
      .ram_wr_i   (RAMWr),
      .rd_data_o  (MDROut)
   );

   assign ld_ready   = (state_q == StLoad);
   assign cpu_rst    = (state_q != StRun);
   assign load_count = load_count_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_fbcpu_mem_loader.sv
// Directed bench for fbcpu_mem_loader: clear pass, loading, CPU access, reload and reset abort.
module tb_fbcpu_mem_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld_valid;
   logic       ld_ready;
   logic [9:0] ld_data;
   logic       ld_last;
   logic       ld_start;
   logic [5:0] MAR;
   logic [9:0] MDRIn;
   logic       RAMWr;
   logic [9:0] MDROut;
   logic       cpu_rst;
   logic [6:0] load_count;
   logic       load_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fbcpu_mem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_start   (ld_start),
      .MAR        (MAR),
      .MDRIn      (MDRIn),
      .RAMWr      (RAMWr),
      .MDROut     (MDROut),
      .cpu_rst    (cpu_rst),
      .load_count (load_count),
      .load_err   (load_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [9:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   // Expects to be called with the FSM at the start of a CLEAR pass (clr_addr = 0).
   task automatic run_clear(input string tag);
      for (int i = 0; i < 63; i++) step();
      chk({tag, "_ready_lo"}, 32'(ld_ready), 32'd0);
      chk({tag, "_cpurst_hi"}, 32'(cpu_rst), 32'd1);
      chk({tag, "_mdr_zero"}, 32'(MDROut), 32'd0);
      step();
      chk({tag, "_ready_hi"}, 32'(ld_ready), 32'd1);
   endtask

   task automatic read_at(input string tag, input logic [5:0] a, input logic [9:0] exp);
      MAR = a;
      step();
      chk(tag, 32'(MDROut), 32'(exp));
   endtask

   task automatic pulse_start();
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; ld_start = 1'b0;
      MAR = '0; MDRIn = '0; RAMWr = 1'b0;
      #3;
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_ready", 32'(ld_ready), 32'd0);
      chk("rst_count", 32'(load_count), 32'd0);
      chk("rst_err", 32'(load_err), 32'd0);
      chk("rst_mdr", 32'(MDROut), 32'd0);
      step();
      step();
      rst = 1'b0;
      run_clear("clr0");

      // ld_start while loading is ignored
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      chk("start_in_load_ready", 32'(ld_ready), 32'd1);
      chk("start_in_load_count", 32'(load_count), 32'd0);

      load_word(10'h040, 1'b0);
      load_word(10'h081, 1'b0);
      load_word(10'h200, 1'b1);
      chk("load3_count", 32'(load_count), 32'd3);
      chk("load3_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("load3_ready", 32'(ld_ready), 32'd0);
      chk("load3_err", 32'(load_err), 32'd0);
      read_at("rd_a1", 6'd1, 10'h081);
      read_at("rd_a0", 6'd0, 10'h040);
      read_at("rd_a2", 6'd2, 10'h200);
      read_at("rd_a9", 6'd9, 10'h000);

      // Read-first on CPU write
      MAR = 6'd5; MDRIn = 10'h155; RAMWr = 1'b1;
      step();
      RAMWr = 1'b0;
      chk("wr5_old", 32'(MDROut), 32'h000);
      step();
      chk("wr5_new", 32'(MDROut), 32'h155);

      // Host words in RUN do nothing
      ld_valid = 1'b1; ld_data = 10'h3ff;
      read_at("run_valid_a3", 6'd3, 10'h000);
      ld_valid = 1'b0;
      chk("run_valid_count", 32'(load_count), 32'd3);

      pulse_start();
      chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("start_count", 32'(load_count), 32'd0);
      chk("start_ready", 32'(ld_ready), 32'd0);
      run_clear("clr1");

      // Stall mid-load
      load_word(10'h011, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_count", 32'(load_count), 32'd1);
      end
      load_word(10'h022, 1'b1);
      chk("stall_final_count", 32'(load_count), 32'd2);
      read_at("stall_a1", 6'd1, 10'h022);
      read_at("stall_a0", 6'd0, 10'h011);
      read_at("stall_a2", 6'd2, 10'h000);
      read_at("clr_a5", 6'd5, 10'h000);

      // 64 words without ld_last
      pulse_start();
      run_clear("clr2");
      for (int i = 0; i < 63; i++) load_word(10'(i + 7), 1'b0);
      chk("full63_count", 32'(load_count), 32'd63);
      chk("full63_ready", 32'(ld_ready), 32'd1);
      load_word(10'h2aa, 1'b0);
      chk("full64_err", 32'(load_err), 32'd1);
      chk("full64_count", 32'(load_count), 32'd64);
      chk("full64_cpu_rst", 32'(cpu_rst), 32'd0);
      read_at("full64_a63", 6'd63, 10'h2aa);
      read_at("full64_a10", 6'd10, 10'd17);

      // 64 words with ld_last on the final one
      pulse_start();
      chk("start_err_clr", 32'(load_err), 32'd0);
      run_clear("clr3");
      for (int i = 0; i < 63; i++) load_word(10'(i), 1'b0);
      load_word(10'h155, 1'b1);
      chk("last64_err", 32'(load_err), 32'd0);
      chk("last64_count", 32'(load_count), 32'd64);
      chk("last64_cpu_rst", 32'(cpu_rst), 32'd0);

      // Asynchronous reset after 10 words
      pulse_start();
      run_clear("clr4");
      for (int i = 0; i < 10; i++) load_word(10'h100 + 10'(i), 1'b0);
      chk("pre_rst_count", 32'(load_count), 32'd10);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count", 32'(load_count), 32'd0);
      chk("arst_ready", 32'(ld_ready), 32'd0);
      chk("arst_cpu_rst", 32'(cpu_rst), 32'd1);
      #1;
      rst = 1'b0;
      run_clear("clr5");
      load_word(10'h3aa, 1'b1);
      read_at("post_rst_a5", 6'd5, 10'h000);
      read_at("post_rst_a0", 6'd0, 10'h3aa);
      read_at("post_rst_a9", 6'd9, 10'h000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fbcpu_mem_loader.md
FBCPU_MEM_LOADER -- requirements
Module: fbcpu_mem_loader

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 6, giving the RAM address width (depth 2^ADDRESS_WIDTH = 64 words).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 10, giving the RAM word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ld_valid  input  1  host load word valid.
REQ-006 ld_ready  output  1  loader accepts a word this cycle.
REQ-007 ld_data  input  DATA_WIDTH  program word to store.
REQ-008 ld_last  input  1  qualifies the final word of a load session.
REQ-009 ld_start  input  1  one-cycle request to reload; honoured only in RUN.
REQ-010 MAR  input  ADDRESS_WIDTH  CPU address.
REQ-011 MDRIn  input  DATA_WIDTH  CPU write data.
REQ-012 RAMWr  input  1  CPU write enable.
REQ-013 MDROut  output  DATA_WIDTH  registered RAM read data to the CPU.
REQ-014 cpu_rst  output  1  drives the CPU's rst; high while the program is not valid.
REQ-015 load_count  output  ADDRESS_WIDTH+1  words accepted in the current or last session (0..64).
REQ-016 load_err  output  1  sticky: 64 words accepted without ld_last.

Function
REQ-017 The FSM SHALL have states CLEAR, LOAD and RUN.
REQ-018 CLEAR SHALL write 0 to address clr_addr each cycle, clr_addr counting 0..63; after writing address 63 the next state SHALL be LOAD.
REQ-019 LOAD SHALL drive ld_ready=1; a word is accepted when ld_valid and ld_ready are both high at a rising edge.
REQ-020 Each accepted word SHALL be written to address load_count, and load_count SHALL increment by 1.
REQ-021 Accepting a word with ld_last=1 SHALL move the FSM to RUN on the same edge.
REQ-022 Accepting the 64th word with ld_last=0 SHALL set load_err=1 and move the FSM to RUN.
REQ-023 The 64th word accepted with ld_last=1 SHALL move the FSM to RUN with load_err=0.
REQ-024 ld_ready SHALL be 0 in CLEAR and RUN.
REQ-025 cpu_rst SHALL be 1 in CLEAR and LOAD and 0 in RUN, decoded from the registered state (no combinational path from ld_*).
REQ-026 In RUN the RAM SHALL be read synchronously: MDROut <= mem[MAR] every edge, one-cycle latency, held until the next edge.
REQ-027 In RUN an edge with RAMWr=1 SHALL write mem[MAR] <= MDRIn; read-during-write to the same address SHALL return the old data (read-first).
REQ-028 Outside RUN, MAR, MDRIn and RAMWr SHALL be ignored and MDROut SHALL be registered to 0.
REQ-029 ld_start=1 in RUN SHALL move the FSM to CLEAR and clear load_count, load_err and clr_addr on that edge; ld_start in CLEAR or LOAD SHALL be ignored.
REQ-030 ld_valid in CLEAR or RUN SHALL be ignored and SHALL NOT write memory.

Reset
REQ-031 rst=1 SHALL asynchronously force state=CLEAR, clr_addr=0, load_count=0, load_err=0, MDROut=0 and cpu_rst=1; ld_ready SHALL read 0.
REQ-032 rst asserted mid-LOAD or mid-RUN SHALL abort the session; memory contents are then zeroed by the following CLEAR pass, not by rst itself.

Structure
REQ-033 ADDRESS_WIDTH, DATA_WIDTH, DEPTH=64 and the state encoding SHALL live in shared package fbcpu_pkg.
REQ-034 Storage SHALL be sub-module fbcpu_ram: single-port, 64x10, synchronous read-first, with a write mux selecting the CLEAR, LOAD or CPU source by state.

Verification
REQ-035 Reset release -> cpu_rst=1 and ld_ready=0 for 64 cycles, then ld_ready=1; reading any address after load returns 0 unless written.
REQ-036 Load 3 words 0x040, 0x081, 0x200 (last on the third) -> load_count=3 and cpu_rst=0 the next cycle; CPU MAR=1 gives MDROut=0x081 one cycle later.
REQ-037 Hold ld_valid low for 5 cycles mid-LOAD, then resume -> no extra writes and load_count unchanged during the stall.
REQ-038 Send 64 words with ld_last=0 -> load_err=1, load_count=64, RUN entered; with ld_last=1 on word 64 -> load_err=0.
REQ-039 In RUN, RAMWr=1, MAR=5, MDRIn=0x155 over old value 0x000 -> MDROut=0x000 that cycle, then MAR=5 read gives 0x155; ld_start pulse -> cpu_rst=1 next cycle and a full CLEAR pass.
REQ-040 Assert rst mid-LOAD after 10 words -> immediate CLEAR, load_count=0 and previously loaded words read 0 after the reload.
